// File: rtl/nlfsr_pkg.sv
// Shared types and constants for the NLFSR state registers of a Trivium-class core.
// Register A/B/C defaults describe the three stages of a standard Trivium instance.
package nlfsr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } nlfsr_state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Register A: s1..s93
    localparam int unsigned TRIV_A_WIDTH       = 93;
    localparam int unsigned TRIV_A_FDBK_OUTPUT = 66;
    localparam int unsigned TRIV_A_FDBK_INPUT  = 69;
    localparam int unsigned TRIV_A_NON_LINEAR  = 92;

    // Register B: s94..s177
    localparam int unsigned TRIV_B_WIDTH       = 84;
    localparam int unsigned TRIV_B_FDBK_OUTPUT = 69;
    localparam int unsigned TRIV_B_FDBK_INPUT  = 78;
    localparam int unsigned TRIV_B_NON_LINEAR  = 83;

    // Register C: s178..s288
    localparam int unsigned TRIV_C_WIDTH       = 111;
    localparam int unsigned TRIV_C_FDBK_OUTPUT = 66;
    localparam int unsigned TRIV_C_FDBK_INPUT  = 87;
    localparam int unsigned TRIV_C_NON_LINEAR  = 110;

    // Four full passes over the 288-bit combined state
    localparam int unsigned TRIV_WARMUP_BITS = 1152;

    // A zero-bit warm-up still needs a one-bit counter to stay legal
    function automatic int unsigned cnt_width(input int unsigned warmup_bits);
        return (warmup_bits == 0) ? 1 : $clog2(warmup_bits + 1);
    endfunction

endpackage

// File: rtl/nlfsr_warmup_ctrl.sv
// Post-load warm-up tracker: counts shifted bits after a load and raises ready
// once the configured number of bits has been clocked through.
module nlfsr_warmup_ctrl
    import nlfsr_pkg::*;
#(
    parameter int unsigned STEP        = 1,
    parameter int unsigned WARMUP_BITS = TRIV_WARMUP_BITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift_en,
    output logic         ready,
    output nlfsr_state_t state
);

    localparam int unsigned CntW = cnt_width(WARMUP_BITS);

    // One spare bit so the step add can never wrap before the compare
    localparam logic [CntW:0] StepExt  = (CntW + 1)'(STEP);
    localparam logic [CntW:0] LimitExt = (CntW + 1)'(WARMUP_BITS);

    nlfsr_state_t    state_d, state_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic            ready_d, ready_q;
    logic [CntW:0]   cnt_sum;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_sum = {1'b0, cnt_q} + StepExt;

        if (load) begin
            cnt_d   = '0;
            state_d = (WARMUP_BITS == 0) ? RUN : WARMUP;
        end else if (shift_en) begin
            unique case (state_q)
                WARMUP: begin
                    if (cnt_sum >= LimitExt) begin
                        cnt_d   = LimitExt[CntW-1:0];
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_sum[CntW-1:0];
                    end
                end
                default: begin
                    // IDLE keeps the counter frozen; RUN keeps it saturated
                    state_d = state_q;
                end
            endcase
        end

        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;
    assign state = state_q;

endmodule

// File: rtl/nlfsr_shift_register.sv
// Bidirectional multi-step NLFSR state register with per-step tap outputs, so the
// surrounding cipher logic can form STEP feedback bits combinationally each cycle.
module nlfsr_shift_register
    import nlfsr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = TRIV_A_WIDTH,
    parameter int unsigned FDBK_OUTPUT      = TRIV_A_FDBK_OUTPUT,
    parameter int unsigned FDBK_INPUT       = TRIV_A_FDBK_INPUT,
    parameter int unsigned NON_LINEAR_INDEX = TRIV_A_NON_LINEAR,
    parameter int unsigned STEP             = 1,
    parameter int unsigned WARMUP_BITS      = TRIV_WARMUP_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  shift_en,
    input  logic                  dir,
    input  logic [STEP-1:0]       input_bits,
    output logic [STEP-1:0]       output_bits,
    output logic [STEP-1:0]       feedback_out,
    output logic [STEP-1:0]       feedback_in,
    output logic [STEP-1:0]       nonlinear,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  ready,
    output logic                  ks_valid
);

    // Taps are walked STEP-1 places in either direction, so both ends must fit
    if (STEP < 1 || STEP > 64 || STEP > DATA_WIDTH) begin : g_bad_step
        $error("nlfsr_shift_register: STEP must be 1..64 and no larger than DATA_WIDTH");
    end
    if (STEP != 0 && (WARMUP_BITS % STEP) != 0) begin : g_bad_warmup
        $error("nlfsr_shift_register: WARMUP_BITS must be a multiple of STEP");
    end
    if (FDBK_OUTPUT < STEP || FDBK_OUTPUT + STEP - 1 > DATA_WIDTH) begin : g_bad_fdbk_out
        $error("nlfsr_shift_register: FDBK_OUTPUT tap range falls outside the register");
    end
    if (FDBK_INPUT < STEP || FDBK_INPUT + STEP - 1 > DATA_WIDTH) begin : g_bad_fdbk_in
        $error("nlfsr_shift_register: FDBK_INPUT tap range falls outside the register");
    end
    if (NON_LINEAR_INDEX < 2 || NON_LINEAR_INDEX < STEP + 1 ||
        NON_LINEAR_INDEX + STEP - 1 > DATA_WIDTH) begin : g_bad_nonlinear
        $error("nlfsr_shift_register: NON_LINEAR_INDEX tap range falls outside the register");
    end

    logic [DATA_WIDTH-1:0] dout_d, dout_q;
    logic [DATA_WIDTH-1:0] shift_right, shift_left;
    logic [STEP-1:0]       input_rev;
    logic                  ready_w;
    nlfsr_state_t          state;

    // Left shifts insert bit 0 first, so it ends up deepest at position STEP-1
    always_comb begin
        input_rev = '0;
        for (int j = 0; j < int'(STEP); j++) begin
            input_rev[int'(STEP) - 1 - j] = input_bits[j];
        end
    end

    if (STEP < DATA_WIDTH) begin : g_shift_partial
        assign shift_right = {input_bits, dout_q[DATA_WIDTH-1:STEP]};
        assign shift_left  = {dout_q[DATA_WIDTH-1-STEP:0], input_rev};
    end else begin : g_shift_full
        assign shift_right = input_bits;
        assign shift_left  = input_rev;
    end

    always_comb begin
        dout_d = dout_q;
        if (load) begin
            dout_d = din;
        end else if (shift_en) begin
            dout_d = (dir == DIR_LEFT) ? shift_left : shift_right;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    for (genvar j = 0; j < int'(STEP); j++) begin : g_tap
        localparam int OutR = j;
        localparam int OutL = int'(DATA_WIDTH) - 1 - j;
        localparam int FoR  = int'(FDBK_OUTPUT) - 1 + j;
        localparam int FoL  = int'(FDBK_OUTPUT) - 1 - j;
        localparam int FiR  = int'(FDBK_INPUT) - 1 + j;
        localparam int FiL  = int'(FDBK_INPUT) - 1 - j;
        localparam int NlR  = int'(NON_LINEAR_INDEX) - 1 + j;
        localparam int NlL  = int'(NON_LINEAR_INDEX) - 1 - j;

        assign output_bits[j]  = (dir == DIR_LEFT) ? dout_q[OutL] : dout_q[OutR];
        assign feedback_out[j] = (dir == DIR_LEFT) ? dout_q[FoL] : dout_q[FoR];
        assign feedback_in[j]  = (dir == DIR_LEFT) ? dout_q[FiL] : dout_q[FiR];
        assign nonlinear[j]    = (dir == DIR_LEFT) ? (dout_q[NlL] & dout_q[NlL-1])
                                                   : (dout_q[NlR] & dout_q[NlR-1]);
    end

    nlfsr_warmup_ctrl #(
        .STEP       (STEP),
        .WARMUP_BITS(WARMUP_BITS)
    ) u_warmup (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .shift_en(shift_en),
        .ready   (ready_w),
        .state   (state)
    );

    assign dout     = dout_q;
    assign ready    = ready_w;
    assign ks_valid = shift_en & ready_w;

endmodule
